// File: rtl/load_store_unit.sv
// Data-memory access stage: one load/store at a time, byte-lane steering for stores,
// LSB-aligned zero-filled load data for ExtendResult, misaligned requests rejected locally.
module load_store_unit #(
  parameter int REG_BITS = 32
) (
  input  logic                  Clk,
  input  logic                  RstN,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [REG_BITS-1:0]   ReqAddr,
  input  logic [REG_BITS-1:0]   ReqWData,
  input  logic [1:0]            ReqSize,
  output logic                  MemReq,
  input  logic                  MemGnt,
  output logic [REG_BITS-1:0]   MemAddr,
  output logic                  MemWe,
  output logic [REG_BITS/8-1:0] MemBe,
  output logic [REG_BITS-1:0]   MemWData,
  input  logic                  MemRValid,
  input  logic [REG_BITS-1:0]   MemRData,
  output logic                  RespValid,
  output logic [REG_BITS-1:0]   RespData,
  output logic                  Misaligned,
  output logic                  Busy
);

  localparam int BE_W = REG_BITS / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_t;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [1:0]          off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                mis_q, mis_d;
  logic [REG_BITS-1:0] addr_q, addr_d;
  logic [REG_BITS-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [REG_BITS-1:0] rdata_q, rdata_d;

  logic                req_mis;
  logic [BE_W-1:0]     req_be;
  logic [REG_BITS-1:0] req_lanes;
  logic [REG_BITS-1:0] rd_shifted;
  logic [REG_BITS-1:0] rd_mask;

  // Request decode: alignment check, byte enables and lane replication.
  always_comb begin
    req_mis   = 1'b0;
    req_be    = '0;
    req_lanes = '0;
    case (ReqSize)
      2'b00: begin
        req_be    = 4'b0001 << ReqAddr[1:0];
        req_lanes = {4{ReqWData[7:0]}};
      end
      2'b01: begin
        req_mis   = ReqAddr[0];
        req_be    = 4'b0011 << ReqAddr[1:0];
        req_lanes = {2{ReqWData[15:0]}};
      end
      2'b10: begin
        req_mis   = |ReqAddr[1:0];
        req_be    = 4'b1111;
        req_lanes = ReqWData;
      end
      default: req_mis = 1'b1;
    endcase
  end

  // Load data is brought down to bit 0 and zero-filled; sign extension happens downstream.
  always_comb begin
    rd_shifted = MemRData >> {off_q, 3'b000};
    case (size_q)
      2'b00:   rd_mask = 32'h0000_00FF;
      2'b01:   rd_mask = 32'h0000_FFFF;
      default: rd_mask = 32'hFFFF_FFFF;
    endcase
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    off_d   = off_q;
    size_d  = size_q;
    mis_d   = mis_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          write_d = ReqWrite;
          off_d   = ReqAddr[1:0];
          size_d  = ReqSize;
          mis_d   = req_mis;
          addr_d  = {ReqAddr[REG_BITS-1:2], 2'b00};
          be_d    = (ReqWrite && !req_mis) ? req_be : '0;
          wdata_d = (ReqWrite && !req_mis) ? req_lanes : '0;
          rdata_d = '0;
          state_d = req_mis ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (MemGnt) state_d = write_q ? RESP : WAIT_R;
      end
      WAIT_R: begin
        if (MemRValid) begin
          rdata_d = rd_shifted & rd_mask;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      mis_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      off_q   <= off_d;
      size_q  <= size_d;
      mis_q   <= mis_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  assign ReqReady   = (state_q == IDLE);
  assign MemReq     = (state_q == ISSUE);
  assign MemAddr    = addr_q;
  assign MemWe      = write_q & (state_q == ISSUE);
  assign MemBe      = be_q & {BE_W{state_q == ISSUE}};
  assign MemWData   = wdata_q;
  assign RespValid  = (state_q == RESP);
  assign RespData   = rdata_q;
  assign Misaligned = mis_q & (state_q == RESP);
  assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus back-to-back and reset sequences.
module tb_load_store_unit;

  logic        Clk = 1'b0;
  logic        RstN;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic [1:0]  ReqSize;
  logic        MemReq;
  logic        MemGnt;
  logic [31:0] MemAddr;
  logic        MemWe;
  logic [3:0]  MemBe;
  logic [31:0] MemWData;
  logic        MemRValid;
  logic [31:0] MemRData;
  logic        RespValid;
  logic [31:0] RespData;
  logic        Misaligned;
  logic        Busy;

  load_store_unit #(.REG_BITS(32)) dut (
    .Clk(Clk), .RstN(RstN),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqSize(ReqSize),
    .MemReq(MemReq), .MemGnt(MemGnt), .MemAddr(MemAddr), .MemWe(MemWe),
    .MemBe(MemBe), .MemWData(MemWData), .MemRValid(MemRValid), .MemRData(MemRData),
    .RespValid(RespValid), .RespData(RespData), .Misaligned(Misaligned), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  sz;
    int          gd;    // ISSUE cycles before grant
    int          rd;    // WAIT_R cycles before rvalid
    logic [31:0] rdat;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] resp;
    int          lat;   // cycle of RespValid, accept cycle = 0
  } vec_t;

  vec_t vecs [12];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    ReqValid  = 1'b0;
    ReqWrite  = 1'b0;
    ReqAddr   = '0;
    ReqWData  = '0;
    ReqSize   = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          cyc, gw, rw, mreq_n;
    bit          done, granted, stable, ready_ok, mis_ok;
    logic [31:0] a0, wd0;
    logic [3:0]  be0;
    logic        we0;
    cyc = 1; gw = 0; rw = 0; mreq_n = 0;
    done = 0; granted = 0; stable = 1; ready_ok = 1; mis_ok = 1;
    a0 = '0; wd0 = '0; be0 = '0; we0 = 1'b0;
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = v.wr; ReqAddr = v.addr; ReqWData = v.wd; ReqSize = v.sz;
    @(posedge Clk); #1;
    idle_inputs();
    while (!done && cyc < 40) begin
      @(negedge Clk);
      if (ReqReady) ready_ok = 0;
      if (RespValid) begin
        done = 1;
        chk($sformatf("v%0d_latency", idx), cyc, v.lat);
        chk($sformatf("v%0d_resp_data", idx), RespData, v.resp);
        chk($sformatf("v%0d_misaligned", idx), {31'b0, Misaligned}, {31'b0, v.mis});
      end else begin
        if (Misaligned) mis_ok = 0;
        if (MemReq) begin
          if (mreq_n == 0) begin
            a0 = MemAddr; be0 = MemBe; wd0 = MemWData; we0 = MemWe;
          end else if ({MemAddr, MemBe, MemWData, MemWe} !== {a0, be0, wd0, we0}) begin
            stable = 0;
          end
          mreq_n++;
          if (gw == v.gd) begin
            MemGnt = 1'b1; granted = 1;
          end else begin
            gw++;
            MemRValid = 1'b1;           // stray rvalid during ISSUE must be ignored
            MemRData  = 32'hDEAD_BEEF;
          end
        end else if (granted && Busy) begin
          if (rw == v.rd) begin
            MemRValid = 1'b1; MemRData = v.rdat;
          end else begin
            rw++;
            MemGnt = 1'b1;              // stray grant during WAIT_R must be ignored
          end
        end
      end
      @(posedge Clk); #1;
      MemGnt = 1'b0; MemRValid = 1'b0; MemRData = 32'h5555_AAAA;
      cyc++;
    end
    chk($sformatf("v%0d_resp_seen", idx), {31'b0, done}, 32'd1);
    chk($sformatf("v%0d_memreq_cycles", idx), mreq_n, v.mis ? 0 : v.gd + 1);
    chk($sformatf("v%0d_ready_low_while_busy", idx), {31'b0, ready_ok}, 32'd1);
    chk($sformatf("v%0d_mis_only_in_resp", idx), {31'b0, mis_ok}, 32'd1);
    if (mreq_n > 0) begin
      chk($sformatf("v%0d_mem_addr", idx), a0, {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d_mem_we", idx), {31'b0, we0}, {31'b0, v.wr});
      chk($sformatf("v%0d_mem_be", idx), {28'b0, be0}, {28'b0, v.be});
      if (v.wr) chk($sformatf("v%0d_mem_wdata", idx), wd0, v.mwd);
      chk($sformatf("v%0d_mem_stable", idx), {31'b0, stable}, 32'd1);
    end
    @(negedge Clk);
    chk($sformatf("v%0d_resp_one_cycle", idx), {31'b0, RespValid}, 32'd0);
    chk($sformatf("v%0d_ready_after", idx), {31'b0, ReqReady}, 32'd1);
  endtask

  initial begin
    int  cyc, rw;
    bit  done, ready_ok, seen_resp, seen_busy;

    //           wr    addr          wd            sz     gd rd rdat          mis   be       mwd           resp          lat
    vecs[0]  = '{1'b0, 32'h0000_0103, 32'h0,        2'b00, 0, 0, 32'hA1B2_C3D4, 1'b0, 4'b0000, 32'h0,        32'h0000_00A1, 3};
    vecs[1]  = '{1'b1, 32'h0000_0202, 32'h1234_BEEF, 2'b01, 3, 0, 32'h0,        1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0,        5};
    vecs[2]  = '{1'b0, 32'h0000_0301, 32'h0,        2'b10, 0, 0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,        1};
    vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0,        2'b11, 0, 0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,        1};
    vecs[4]  = '{1'b0, 32'h0000_0002, 32'h0,        2'b01, 0, 0, 32'h8001_1234, 1'b0, 4'b0000, 32'h0,        32'h0000_8001, 3};
    vecs[5]  = '{1'b0, 32'h0000_0400, 32'h0,        2'b10, 0, 4, 32'hCAFE_F00D, 1'b0, 4'b0000, 32'h0,        32'hCAFE_F00D, 7};
    vecs[6]  = '{1'b1, 32'h0000_0001, 32'hAABB_CC5A, 2'b00, 0, 0, 32'h0,        1'b0, 4'b0010, 32'h5A5A_5A5A, 32'h0,        2};
    vecs[7]  = '{1'b1, 32'h0000_0008, 32'h1234_5678, 2'b10, 1, 0, 32'h0,        1'b0, 4'b1111, 32'h1234_5678, 32'h0,        3};
    vecs[8]  = '{1'b0, 32'h0000_0101, 32'h0,        2'b00, 0, 0, 32'hA1B2_C3D4, 1'b0, 4'b0000, 32'h0,        32'h0000_00C3, 3};
    vecs[9]  = '{1'b1, 32'h0000_0003, 32'h0000_FFFF, 2'b01, 0, 0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,        1};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,        2'b01, 2, 1, 32'h8001_1234, 1'b0, 4'b0000, 32'h0,        32'h0000_1234, 6};
    vecs[11] = '{1'b0, 32'h0000_0102, 32'h0,        2'b00, 1, 2, 32'hA1B2_C3D4, 1'b0, 4'b0000, 32'h0,        32'h0000_00B2, 6};

    idle_inputs();
    MemGnt = 1'b0; MemRValid = 1'b0; MemRData = '0;
    RstN = 1'b0;
    #12;
    chk("rst_memreq",   {31'b0, MemReq},     32'd0);
    chk("rst_memwe",    {31'b0, MemWe},      32'd0);
    chk("rst_membe",    {28'b0, MemBe},      32'd0);
    chk("rst_memwdata", MemWData,            32'd0);
    chk("rst_memaddr",  MemAddr,             32'd0);
    chk("rst_respvld",  {31'b0, RespValid},  32'd0);
    chk("rst_respdata", RespData,            32'd0);
    chk("rst_misalign", {31'b0, Misaligned}, 32'd0);
    chk("rst_busy",     {31'b0, Busy},       32'd0);
    chk("rst_ready",    {31'b0, ReqReady},   32'd1);
    @(posedge Clk); #1;
    RstN = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Back-to-back: ReqValid stays high with a second request queued behind a slow load.
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 32'h400; ReqWData = '0; ReqSize = 2'b10;
    @(posedge Clk); #1;
    ReqWrite = 1'b1; ReqAddr = 32'h4; ReqWData = 32'h0000_0077; ReqSize = 2'b00;
    cyc = 1; rw = 0; done = 0; ready_ok = 1;
    while (!done && cyc < 40) begin
      @(negedge Clk);
      if (ReqReady) ready_ok = 0;
      if (RespValid) begin
        done = 1;
        chk("b2b_latency", cyc, 7);
        chk("b2b_resp_data", RespData, 32'h89AB_CDEF);
      end else if (MemReq) begin
        MemGnt = 1'b1;
      end else if (Busy) begin
        if (rw == 4) begin
          MemRValid = 1'b1; MemRData = 32'h89AB_CDEF;
        end else rw++;
      end
      @(posedge Clk); #1;
      MemGnt = 1'b0; MemRValid = 1'b0;
      cyc++;
    end
    chk("b2b_resp_seen", {31'b0, done}, 32'd1);
    chk("b2b_ready_low", {31'b0, ready_ok}, 32'd1);
    @(negedge Clk);
    chk("b2b_idle_ready", {31'b0, ReqReady}, 32'd1);
    @(posedge Clk); #1;
    idle_inputs();
    @(negedge Clk);
    chk("b2b_second_memreq", {31'b0, MemReq}, 32'd1);
    chk("b2b_second_be", {28'b0, MemBe}, 32'h1);
    chk("b2b_second_wdata", MemWData, 32'h7777_7777);
    chk("b2b_second_addr", MemAddr, 32'h4);
    MemGnt = 1'b1;
    @(posedge Clk); #1;
    MemGnt = 1'b0;
    @(negedge Clk);
    chk("b2b_second_resp", {31'b0, RespValid}, 32'd1);
    chk("b2b_second_mis", {31'b0, Misaligned}, 32'd0);

    // Reset during ISSUE: MemReq must drop without waiting for a clock edge.
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 32'h10; ReqSize = 2'b10;
    @(posedge Clk); #1;
    idle_inputs();
    @(negedge Clk);
    chk("rst_issue_memreq_before", {31'b0, MemReq}, 32'd1);
    #2 RstN = 1'b0;
    #1;
    chk("rst_issue_memreq_async", {31'b0, MemReq}, 32'd0);
    @(posedge Clk); #1;
    RstN = 1'b1;

    // Reset during WAIT_R, then a late rvalid must be ignored.
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 32'h10; ReqSize = 2'b10;
    @(posedge Clk); #1;
    idle_inputs();
    @(negedge Clk);
    MemGnt = 1'b1;
    @(posedge Clk); #1;
    MemGnt = 1'b0;
    @(negedge Clk);
    chk("rst_waitr_busy_before", {31'b0, Busy}, 32'd1);
    #2 RstN = 1'b0;
    #1;
    chk("rst_waitr_busy_async", {31'b0, Busy}, 32'd0);
    chk("rst_waitr_memreq", {31'b0, MemReq}, 32'd0);
    chk("rst_waitr_ready", {31'b0, ReqReady}, 32'd1);
    @(posedge Clk); #1;
    RstN = 1'b1;
    MemRValid = 1'b1; MemRData = 32'h1234_5678;
    seen_resp = 0; seen_busy = 0;
    repeat (3) begin
      @(negedge Clk);
      if (RespValid) seen_resp = 1;
      if (Busy) seen_busy = 1;
    end
    @(posedge Clk); #1;
    MemRValid = 1'b0;
    chk("rst_late_rvalid_no_resp", {31'b0, seen_resp}, 32'd0);
    chk("rst_late_rvalid_no_busy", {31'b0, seen_busy}, 32'd0);
    chk("rst_late_rvalid_respdata", RespData, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
